// File: rtl/sha256_round_ctrl_if.sv
// Bus bundle between the SHA-256 round controller, its block source, the
// compression-round datapath and the digest consumer.
`timescale 1ns/1ps

interface sha256_round_ctrl_if;
    // Valid/ready: a block or digest moves on a rising clk edge where both
    // valid and ready are high. Once raised, valid and the payload are held
    // until that edge; ready may change freely and never waits on valid.
    logic         is224;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_first;
    logic [511:0] blk_data;
    logic         ml_enable;
    logic [511:0] ml_raw;
    logic [31:0]  ml_k;
    logic [31:0]  ml_w;
    logic [511:0] ml_ripe;
    logic         dig_valid;
    logic         dig_ready;
    logic [255:0] digest;

    modport master (
        input  is224, blk_valid, blk_first, blk_data, ml_ripe, dig_ready,
        output blk_ready, ml_enable, ml_raw, ml_k, ml_w, dig_valid, digest
    );

    modport slave (
        output is224, blk_valid, blk_first, blk_data, ml_ripe, dig_ready,
        input  blk_ready, ml_enable, ml_raw, ml_k, ml_w, dig_valid, digest
    );
endinterface

// File: rtl/sha256_round_ctrl.sv
// SHA-224/256 round controller: message schedule, K ROM, round sequencing,
// final chaining addition and digest hand-off.
`timescale 1ns/1ps

module sha256_round_ctrl #(
    parameter int NROUNDS = 64
) (
    input  logic                clk,
    input  logic                rstn,
    sha256_round_ctrl_if.master bus,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    localparam logic [6:0] CNT_LAST = 7'(NROUNDS - 1);

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV256 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] IV224 [8] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    state_t      state_q;
    state_t      state_d;
    logic [6:0]  cnt_q;
    logic        is224_q;
    logic [31:0] h_q [8];
    logic [31:0] w_q [16];
    logic [31:0] w_next;

    assign dbg_state = state_q;

    // Sliding 16-word window: w_q[0] is W[t], w_next becomes W[t+16].
    assign w_next = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.blk_valid) state_d = ROUND;
            ROUND:   if (cnt_q == CNT_LAST) state_d = FINAL;
            FINAL:   state_d = DONE;
            DONE:    if (bus.dig_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= '0;
            is224_q <= 1'b0;
            for (int i = 0; i < 8; i++) h_q[i] <= '0;
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.blk_valid) begin
                        is224_q <= bus.is224;
                        cnt_q   <= '0;
                        for (int i = 0; i < 16; i++) w_q[i] <= bus.blk_data[511-32*i -: 32];
                        if (bus.blk_first) begin
                            for (int i = 0; i < 8; i++) h_q[i] <= bus.is224 ? IV224[i] : IV256[i];
                        end
                    end
                end
                ROUND: begin
                    for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
                    w_q[15] <= w_next;
                    cnt_q   <= cnt_q + 7'd1;
                end
                FINAL: begin
                    // Only the low half of each ripe word carries state.
                    for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + bus.ml_ripe[479-64*i -: 32];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.blk_ready = 1'b0;
        bus.ml_enable = 1'b0;
        bus.ml_raw    = '0;
        bus.ml_k      = '0;
        bus.ml_w      = '0;
        bus.dig_valid = 1'b0;
        bus.digest    = '0;
        case (state_q)
            IDLE: bus.blk_ready = 1'b1;
            ROUND: begin
                bus.ml_enable = 1'b1;
                bus.ml_k      = K_ROM[cnt_q[5:0]];
                bus.ml_w      = w_q[0];
                if (cnt_q == 7'd0) begin
                    for (int i = 0; i < 8; i++) bus.ml_raw[479-64*i -: 32] = h_q[i];
                end else begin
                    bus.ml_raw = bus.ml_ripe;
                end
            end
            DONE: begin
                bus.dig_valid = 1'b1;
                for (int i = 0; i < 8; i++) bus.digest[255-32*i -: 32] = h_q[i];
                if (is224_q) bus.digest[31:0] = '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: a behavioural round datapath, a full-block
// SHA-256 reference model and a digest scoreboard.
`timescale 1ns/1ps

module tb_sha256_round_ctrl;

    localparam int NROUNDS = 64;

    localparam logic [31:0] K_TB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV256 =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] IV224 =
        256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] TWO_BLK1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_BLK2 = {448'h0, 64'h1c0};

    localparam logic [255:0] ABC256 =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] ABC224 =
        256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
    localparam logic [255:0] TWO256 =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    logic       clk;
    logic       rstn;
    logic [1:0] dbg_state;

    sha256_round_ctrl_if bus ();

    sha256_round_ctrl #(.NROUNDS(NROUNDS)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [255:0] exp_q [$];
    logic [255:0] model_h;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] round_step(input logic [255:0] v, input logic [31:0] k, input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = v;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [255:0] v;
        logic [255:0] hout;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        v = hin;
        for (int t = 0; t < 64; t++) v = round_step(v, K_TB[t], w[t]);
        for (int i = 0; i < 8; i++) hout[255-32*i -: 32] = hin[255-32*i -: 32] + v[255-32*i -: 32];
        return hout;
    endfunction

    // ---------------- round datapath (slave side) ----------------
    function automatic logic [511:0] dp_round(input logic [511:0] raw, input logic [31:0] k, input logic [31:0] w);
        logic [255:0] v;
        logic [255:0] n;
        logic [511:0] r;
        for (int i = 0; i < 8; i++) v[255-32*i -: 32] = raw[479-64*i -: 32];
        n = round_step(v, k, w);
        r = '0;
        for (int i = 0; i < 8; i++) r[479-64*i -: 32] = n[255-32*i -: 32];
        return r;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) bus.ml_ripe <= '0;
        else if (bus.ml_enable) bus.ml_ripe <= dp_round(bus.ml_raw, bus.ml_k, bus.ml_w);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    int          rnd = 0;
    logic        prev_en = 1'b0;
    logic        raw_hi_seen = 1'b0;
    logic [31:0] w_log [64];
    logic [31:0] k_log [64];

    // Monitor: logs the round strobes and scores every digest transfer.
    always @(negedge clk) begin
        if (bus.ml_enable) begin
            if (!prev_en) rnd = 0;
            if (rnd < 64) begin
                w_log[rnd] = bus.ml_w;
                k_log[rnd] = bus.ml_k;
            end
            for (int i = 0; i < 8; i++) raw_hi_seen = raw_hi_seen | (|bus.ml_raw[511-64*i -: 32]);
            rnd++;
        end
        prev_en = bus.ml_enable;
        if (rstn && bus.dig_valid && bus.dig_ready) begin
            if (exp_q.size() == 0) check("digest_unexpected", bus.digest, '0 - 256'd1);
            else check("digest", bus.digest, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic offer_block(input logic [511:0] blk, input bit first, input bit m224, output bit ok);
        int guard = 0;
        @(negedge clk);
        while (!bus.blk_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        ok = bus.blk_ready;
        check("blk_ready_wait", 256'(bus.blk_ready), 256'd1);
        bus.blk_data  = blk;
        bus.blk_first = first;
        bus.is224     = m224;
        bus.blk_valid = ok;
        @(posedge clk);
        #1;
        bus.blk_valid = 1'b0;
        bus.blk_first = 1'($urandom_range(0, 1));
        bus.is224     = 1'($urandom_range(0, 1));
        for (int i = 0; i < 16; i++) bus.blk_data[32*i +: 32] = $urandom();
    endtask

    task automatic send_block(input logic [511:0] blk, input bit first, input bit m224, input int rdy_delay,
                              input bit has_known, input logic [255:0] known);
        bit          ok;
        int          lat;
        logic        busy_bad;
        logic        hold_bad;
        logic [255:0] snap;
        if (first) model_h = m224 ? IV224 : IV256;
        model_h = compress(model_h, blk);
        exp_q.push_back(has_known ? known : (m224 ? {model_h[255:32], 32'd0} : model_h));
        bus.dig_ready = (rdy_delay == 0);
        raw_hi_seen   = 1'b0;
        offer_block(blk, first, m224, ok);
        lat      = 0;
        busy_bad = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (!bus.dig_valid) busy_bad = busy_bad | bus.blk_ready;
        end while (!bus.dig_valid && lat < 200);
        check("dig_valid_latency", 256'(lat), 256'd66);
        check("enable_cycles", 256'(rnd), 256'(NROUNDS));
        check("blk_ready_busy", 256'(busy_bad), 256'd0);
        check("raw_upper_zero", 256'(raw_hi_seen), 256'd0);
        if (rdy_delay > 0) begin
            snap     = bus.digest;
            hold_bad = 1'b0;
            @(posedge clk);
            #1 bus.blk_valid = 1'b1;
            for (int i = 0; i < rdy_delay; i++) begin
                @(negedge clk);
                hold_bad = hold_bad | (bus.digest !== snap) | bus.blk_ready | !bus.dig_valid | bus.ml_enable;
            end
            check("backpressure_hold", 256'(hold_bad), 256'd0);
            @(posedge clk);
            #1;
            bus.blk_valid = 1'b0;
            bus.dig_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("post_xfer_idle", {254'd0, bus.dig_valid, bus.blk_ready}, 256'd1);
        bus.dig_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [511:0] rblk;
        bit           ok;
        bit           first;
        rstn          = 1'b0;
        model_h       = '0;
        bus.is224     = 1'b0;
        bus.blk_valid = 1'b0;
        bus.blk_first = 1'b0;
        bus.blk_data  = '0;
        bus.dig_ready = 1'b0;
        #12;
        check("reset_blk_ready", 256'(bus.blk_ready), 256'd1);
        check("reset_outputs", {250'd0, bus.ml_enable, |bus.ml_raw, |bus.ml_k, |bus.ml_w, bus.dig_valid, |bus.digest}, 256'd0);
        @(negedge clk);
        rstn = 1'b1;

        send_block(ABC_BLK, 1'b1, 1'b0, 0, 1'b1, ABC256);
        check("w_round16", 256'(w_log[16]), 256'h61626380);
        check("w_round63", 256'(w_log[63]), 256'h12b1edeb);
        check("k_round0", 256'(k_log[0]), 256'h428a2f98);
        check("k_round63", 256'(k_log[63]), 256'hc67178f2);

        send_block(ABC_BLK, 1'b1, 1'b1, 3, 1'b1, ABC224);
        send_block(TWO_BLK1, 1'b1, 1'b0, 1, 1'b0, '0);
        send_block(TWO_BLK2, 1'b0, 1'b0, 0, 1'b1, TWO256);
        send_block(ABC_BLK, 1'b1, 1'b0, 10, 1'b1, ABC256);

        // Abort a block at round 30 with an asynchronous reset.
        offer_block(ABC_BLK, 1'b1, 1'b0, ok);
        repeat (31) @(negedge clk);
        check("round30_active", {224'd0, bus.ml_k}, {224'd0, K_TB[30]});
        #2 rstn = 1'b0;
        model_h = '0;
        #1;
        check("async_reset_outputs", {250'd0, bus.ml_enable, |bus.ml_raw, |bus.ml_k, |bus.ml_w, bus.dig_valid, |bus.digest}, 256'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("blk_ready_after_reset", 256'(bus.blk_ready), 256'd1);
        send_block(ABC_BLK, 1'b1, 1'b0, 0, 1'b1, ABC256);

        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 16; i++) rblk[32*i +: 32] = $urandom();
            first = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            send_block(rblk, first, 1'($urandom_range(0, 1)), $urandom_range(0, 4), 1'b0, '0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 256'(exp_q.size()), 256'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sha256_round_ctrl.md
Name: sha256_round_ctrl

Overview:
Round controller and message scheduler that acts as master for the SHA-224/256 compression-round datapath (sha_mainloop_if slave side).
- Accepts one 512-bit padded message block per transaction.
- Drives 64 round cycles, supplying K[t], W[t] and the working variables.
- Performs the final chaining addition and presents the digest on a valid/ready output.
- Sits between the padding/block buffer and the top-level digest register.

Parameters:
- NROUNDS, 64, number of compression rounds; fixed at 64 for SHA-2/256, exposed for bench shortening only.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- is224  in  1  1 = SHA-224 IV and truncated digest; 0 = SHA-256. Sampled at block accept.
- blk_valid  in  1  block present.
- blk_ready  out  1  controller can accept a block.
- blk_first  in  1  1 = start from IV; 0 = chain from current H. Sampled at accept.
- blk_data  in  512  message block; word 0 = bits [511:480], big-endian.
- ml_enable  out  1  round strobe to the datapath.
- ml_raw  out  512  8 x 64-bit working variables a..h, with a in [511:448]; upper 32 bits of each word = 0.
- ml_k  out  32  round constant K[t].
- ml_w  out  32  schedule word W[t].
- ml_ripe  in  512  registered next working variables from the datapath, same packing as ml_raw.
- dig_valid  out  1  digest available.
- dig_ready  in  1  digest consumer ready.
- digest  out  256  H0 in [255:224]. In SHA-224 mode [31:0] = 0.

Behaviour:
- Reset (async, rstn=0):
  - State IDLE, round counter = 0.
  - H0..H7 = 0, schedule window = 0.
  - Outputs: blk_ready=1, ml_enable=0, ml_raw=0, ml_k=0, ml_w=0, dig_valid=0, digest=0.
- States: IDLE, ROUND, FINAL, DONE.
- IDLE:
  - blk_ready = 1.
  - On blk_valid && blk_ready:
    - Latch is224.
    - Load the 16-word window w[0..15] from blk_data.
    - If blk_first, load H with the IV: SHA-256 = 6a09e667..5be0cd19; SHA-224 = c1059ed8..befa4fa4. Otherwise H is unchanged.
    - cnt = 0; go to ROUND.
- ROUND (exactly NROUNDS cycles):
  - ml_enable = 1, ml_k = K[cnt] from the internal 64-entry ROM, ml_w = w[0].
  - ml_raw = H (zero-extended) when cnt = 0, else ml_ripe.
  - Each cycle, the window shifts: w[i] <= w[i+1]. The new entry is w[15] <= s1(w[14]) + w[9] + s0(w[1]) + w[0], all mod 2^32.
    - s0 = ror7 ^ ror18 ^ shr3.
    - s1 = ror17 ^ ror19 ^ shr10.
  - cnt increments each cycle. At cnt = NROUNDS-1, go to FINAL.
- FINAL (1 cycle):
  - ml_enable = 0.
  - H[i] <= H[i] + ml_ripe word i [31:0], mod 2^32. Carries are discarded and the ripe upper halves are ignored.
  - Go to DONE.
- DONE:
  - dig_valid = 1. digest = {H0..H7}; in SHA-224 mode {H0..H6, 32'd0}.
  - digest is stable while dig_valid && !dig_ready.
  - On dig_ready, go to IDLE (dig_valid = 0 the next cycle).
  - H is retained for chaining.
- Handshakes:
  - blk_ready = 0 in ROUND, FINAL and DONE, so a new block is never accepted until the digest is taken.
  - blk_data and blk_first need only be valid in the accept cycle.
- Latency: accept at cycle 0. ml_enable is high for cycles 1..64, FINAL is cycle 65, and dig_valid rises at cycle 66.
- ml_enable, ml_k and ml_w are 0 outside ROUND.
- Simultaneous events: dig_ready arriving in the same cycle as dig_valid rises completes the transfer in that cycle.
- Reset mid-operation: immediate return to the reset values above. H is cleared, so the next block must carry blk_first=1; a chained block after reset hashes from zero state by design.

Test Plan:
- SHA-256 "abc": block 61626380, 13 zero words, 00000018, first=1 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, dig_valid at cycle 66.
- SHA-224 "abc": same block, is224=1 -> digest 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.
- Two-block chaining: "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", block 1 with first=1, block 2 with first=0 -> final digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Backpressure: dig_ready held low 10 cycles after dig_valid -> digest stable, blk_ready=0, blk_valid ignored; dig_ready=1 -> IDLE and blk_ready=1 next cycle.
- Schedule check: "abc" block -> ml_w at rounds 16 and 63 = 61626380 and 12b1edeb; ml_k at rounds 0 and 63 = 428a2f98 and c67178f2; ml_enable high exactly 64 cycles.
- Reset at round 30: rstn pulsed low -> all outputs 0 asynchronously, blk_ready=1 after release; a following "abc" block with first=1 -> correct digest.
